// File: rtl/wb_port_arb4.sv
// wb_port_arb4: four-way round-robin writeback arbiter driving a mux4 select into a one-entry output register.
// Optional burst locking is enabled with the WB_PORT_ARB4_LOCK_EN macro, which adds the req_last input.
module wb_port_arb4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic [3:0]       req_valid,
`ifdef WB_PORT_ARB4_LOCK_EN
  input  logic [3:0]       req_last,
`endif
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [1:0]       mux_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, off, win, lock_id;
  logic [3:0] elig, rot;
  logic any, accept, last, locked;
  logic [WIDTH-1:0] mux_data;
`ifdef WB_PORT_ARB4_LOCK_EN
  always_ff @(posedge clk or negedge rst_aL)
    if (!rst_aL) begin
      locked <= 1'b0;
      lock_id <= 2'd0;
    end else if (accept) begin
      locked <= !req_last[win];
      lock_id <= win;
    end
  assign last = req_last[win];
`else
  assign locked = 1'b0;
  assign lock_id = 2'd0;
  assign last = 1'b1;
`endif
  assign elig = locked ? (req_valid & (4'b0001 << lock_id)) : req_valid;
  // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner's offset.
  assign rot = 4'({elig, elig} >> ptr);
  assign any = |rot;
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign win = ptr + off;
  assign out_valid = (state == FULL);
  assign accept = rst_aL && any && (!out_valid || out_ready);
  assign req_ready = accept ? (4'b0001 << win) : 4'b0000;
  assign mux_sel = !rst_aL ? 2'd0 : any ? win : out_src;
  assign mux_data = mux_sel == 2'd0 ? req_data0 : mux_sel == 2'd1 ? req_data1 :
                    mux_sel == 2'd2 ? req_data2 : req_data3;
  always_comb state_nx = accept ? FULL : out_ready ? EMPTY : state;
  always_ff @(posedge clk or negedge rst_aL)
    if (!rst_aL) state <= EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_aL)
    if (!rst_aL) begin
      out_data <= '0;
      out_src <= 2'd0;
      ptr <= 2'd0;
    end else if (accept) begin
      out_data <= mux_data;
      out_src <= win;
      if (last) ptr <= win + 2'd1;
    end
endmodule
